// File: rtl/tap_tempo.sv
// rtl/tap_tempo.sv - tap interval measurement producing a debounced, averaged tempo period
module tap_tempo #(
  parameter logic [31:0] MIN_PERIOD     = 32'd2_500_000,
  parameter logic [31:0] MAX_PERIOD     = 32'd100_000_000,
  parameter logic [31:0] DEFAULT_PERIOD = 32'd25_000_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        tap,
  output logic [31:0] period,
  output logic        period_update,
  output logic        tapping,
  output logic [2:0]  intervals
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TRACKING
  } state_t;

  // Sequence tracking state
  state_t      state_q, state_d;
  logic        tap_prev_q, tap_prev_d;
  logic [31:0] elapsed_q, elapsed_d;
  logic [31:0] hist_q [4];
  logic [31:0] hist_d [4];
  logic [2:0]  cnt_q, cnt_d;
  logic        acc_q, acc_d;

  // Registered outputs, one cycle behind the accept decision
  logic [31:0] period_q, period_d;
  logic        period_update_q, period_update_d;
  logic [2:0]  intervals_q, intervals_d;

  logic        edge_det;
  logic        timed_out;
  logic        in_range;
  logic [33:0] hist_sum;

  // Rising-edge detect against the previous tap sample
  always_comb begin
    edge_det  = tap & ~tap_prev_q;
    timed_out = (elapsed_q > MAX_PERIOD);
    in_range  = (elapsed_q >= MIN_PERIOD) && !timed_out;
  end

  // Next-state: counter, history, interval count and accept pulse
  always_comb begin
    state_d    = state_q;
    tap_prev_d = tap;
    // Counter saturates one past MAX_PERIOD so "timed out" stays a stable condition
    elapsed_d  = timed_out ? (MAX_PERIOD + 32'd1) : (elapsed_q + 32'd1);
    cnt_d      = cnt_q;
    acc_d      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hist_d[i] = hist_q[i];
    end

    case (state_q)
      S_IDLE: begin
        if (edge_det) begin
          state_d   = S_ARMED;
          elapsed_d = 32'd1;
        end
      end
      default: begin
        if (timed_out) begin
          // Abandoned sequence; an edge arriving now starts a fresh one
          cnt_d = 3'd0;
          for (int i = 0; i < 4; i++) begin
            hist_d[i] = 32'd0;
          end
          if (edge_det) begin
            state_d   = S_ARMED;
            elapsed_d = 32'd1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (edge_det && in_range) begin
          // Restart at 1 so the count seen at the next edge equals the cycle distance
          hist_d[3] = hist_q[2];
          hist_d[2] = hist_q[1];
          hist_d[1] = hist_q[0];
          hist_d[0] = elapsed_q;
          cnt_d     = (cnt_q == 3'd4) ? 3'd4 : (cnt_q + 3'd1);
          elapsed_d = 32'd1;
          state_d   = S_TRACKING;
          acc_d     = 1'b1;
        end
        // Edges shorter than MIN_PERIOD are bounce: counter keeps running untouched
      end
    endcase
  end

  // Period computation from the history captured on the previous cycle
  always_comb begin
    hist_sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]}
             + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};
    period_d        = period_q;
    period_update_d = acc_q;
    intervals_d     = cnt_q;
    if (acc_q) begin
      if (cnt_q == 3'd4) begin
        period_d = 32'(hist_sum >> 2);
      end else begin
        period_d = hist_q[0];
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q         <= S_IDLE;
      tap_prev_q      <= 1'b0;
      elapsed_q       <= 32'd0;
      cnt_q           <= 3'd0;
      acc_q           <= 1'b0;
      period_q        <= DEFAULT_PERIOD;
      period_update_q <= 1'b0;
      intervals_q     <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= 32'd0;
      end
    end else begin
      state_q         <= state_d;
      tap_prev_q      <= tap_prev_d;
      elapsed_q       <= elapsed_d;
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      period_q        <= period_d;
      period_update_q <= period_update_d;
      intervals_q     <= intervals_d;
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= hist_d[i];
      end
    end
  end

  assign period        = period_q;
  assign period_update = period_update_q;
  assign intervals     = intervals_q;
  assign tapping       = (state_q != S_IDLE);

endmodule

// File: tb/tb_tap_tempo.sv
// tb/tb_tap_tempo.sv - scoreboard bench for tap_tempo
`timescale 1ns/1ps
module tb_tap_tempo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tap = 1'b0;
  logic [31:0] period;
  logic        period_update;
  logic        tapping;
  logic [2:0]  intervals;

  always #5 clk = ~clk;

  tap_tempo #(
    .MIN_PERIOD    (32'd10),
    .MAX_PERIOD    (32'd1000),
    .DEFAULT_PERIOD(32'd500)
  ) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .tap          (tap),
    .period       (period),
    .period_update(period_update),
    .tapping      (tapping),
    .intervals    (intervals)
  );

  typedef struct {
    int          cyc;
    logic [31:0] per;
    int          ivl;
  } exp_t;

  exp_t sb[$];
  int   ed_q[$];
  int   ep_q[$];
  int   ei_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   gcyc    = 0;
  logic prev_upd = 1'b0;
  exp_t mon_e;

  always @(posedge clk) gcyc = gcyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Monitor: every update pulse must match the oldest expected update
  always @(negedge clk) begin
    if (period_update) begin
      check("upd_not_back_to_back", {31'd0, prev_upd}, 32'd0);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL upd_unexpected: got update period=%0d intervals=%0d, required no update", period, intervals);
      end else begin
        mon_e = sb.pop_front();
        check("upd_cycle", gcyc, mon_e.cyc);
        check("upd_period", period, mon_e.per);
        check("upd_intervals", {29'd0, intervals}, mon_e.ivl);
      end
    end
    prev_upd = period_update;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_edge(input int c, input int p, input int i);
    ed_q.push_back(c);
    ep_q.push_back(p);
    ei_q.push_back(i);
  endtask

  // Drive a one-sample tap pulse at each listed cycle; ivl>0 means an update is expected
  task automatic run(input int len);
    int   k;
    logic is_e;
    exp_t e;
    k = 0;
    for (int c = 0; c < len; c++) begin
      is_e = (k < ed_q.size()) && (ed_q[k] == c);
      tap = is_e;
      if (is_e && ei_q[k] > 0) begin
        e.cyc = gcyc + 2;
        e.per = ep_q[k];
        e.ivl = ei_q[k];
        sb.push_back(e);
      end
      tick();
      if (is_e) begin
        check("tapping_after_edge", {31'd0, tapping}, 32'd1);
        k++;
      end
    end
    tap = 1'b0;
    ed_q.delete();
    ep_q.delete();
    ei_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tap   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_period"}, period, 32'd500);
    check({tag, "_update"}, {31'd0, period_update}, 32'd0);
    check({tag, "_tapping"}, {31'd0, tapping}, 32'd0);
    check({tag, "_intervals"}, {29'd0, intervals}, 32'd0);
  endtask

  initial begin
    // Reset with tap toggling
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tap = (i == 0);
      tick();
      check_idle("rst");
    end
    reset = 1'b0;
    tap   = 1'b0;
    tick();
    check_idle("rst_after");

    // Basic measure
    do_reset();
    add_edge(0, 0, 0);
    add_edge(100, 100, 1);
    add_edge(200, 100, 2);
    run(205);
    check("basic_period", period, 32'd100);
    check("basic_intervals", {29'd0, intervals}, 32'd2);

    // Averaging over four intervals
    do_reset();
    add_edge(0, 0, 0);
    add_edge(100, 100, 1);
    add_edge(204, 104, 2);
    add_edge(300, 96, 3);
    add_edge(402, 100, 4);
    add_edge(508, 102, 4);
    run(512);
    check("avg_period", period, 32'd102);
    check("avg_intervals", {29'd0, intervals}, 32'd4);

    // Bounce rejection and both interval bounds
    do_reset();
    add_edge(0, 0, 0);
    add_edge(5, 0, 0);
    add_edge(8, 0, 0);
    add_edge(10, 10, 1);
    add_edge(1010, 1000, 2);
    add_edge(2011, 0, 0);
    run(2015);
    check("bound_intervals", {29'd0, intervals}, 32'd0);
    check("bound_period", period, 32'd1000);
    check("bound_tapping", {31'd0, tapping}, 32'd1);

    // Timeout of an abandoned sequence
    do_reset();
    add_edge(0, 0, 0);
    add_edge(100, 100, 1);
    run(1101);
    check("to_tapping_before", {31'd0, tapping}, 32'd1);
    tick();
    check("to_tapping_fall", {31'd0, tapping}, 32'd0);
    tick();
    check("to_intervals", {29'd0, intervals}, 32'd0);
    check("to_period_hold", period, 32'd100);
    run(890);
    add_edge(0, 0, 0);
    add_edge(50, 50, 1);
    run(55);
    check("to_new_period", period, 32'd50);
    check("to_new_intervals", {29'd0, intervals}, 32'd1);

    // Reset in the middle of tracking
    do_reset();
    add_edge(0, 0, 0);
    add_edge(100, 100, 1);
    add_edge(204, 104, 2);
    run(250);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midrst");
    add_edge(0, 0, 0);
    run(20);
    check("midrst_edge_intervals", {29'd0, intervals}, 32'd0);
    check("midrst_edge_period", period, 32'd500);
    check("midrst_edge_tapping", {31'd0, tapping}, 32'd1);

    tick();
    tick();
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
